// File: rtl/nanov_fetch_pkg.sv
// Shared types and constants for the nanoV SPI instruction fetch stage.
package nanov_fetch_pkg;

   localparam int unsigned ADDR_BITS    = 24;
   localparam int unsigned WORD_BITS    = 32;
   localparam logic [7:0]  SPI_READ_CMD = 8'h03;

   typedef enum logic [2:0] {
      StDesel,
      StCmd,
      StAddr,
      StData,
      StStall
   } fetch_state_e;

   // Received bit k lands in instr[8*(k/8) + 7 - (k%8)]: byte order kept, bits MSB first.
   function automatic logic [4:0] rx_bit_index(input logic [4:0] k);
      return {k[4:3], ~k[2:0]};
   endfunction

endpackage

// File: rtl/nanov_spi_phy.sv
// SPI mode-0 bit engine: sck phase generation, MOSI shift-out and MISO capture.
module nanov_spi_phy
   import nanov_fetch_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 abort_i,    // idle the bus: sck low, counters cleared
   input  logic                 start_i,    // load a command frame and drive its first bit
   input  logic [WORD_BITS-1:0] frame_i,
   input  logic                 run_i,      // a transaction is open
   input  logic                 hold_i,     // freeze with sck low, nothing shifts
   input  logic                 spi_miso_i,
   output logic                 spi_sck_o,
   output logic                 spi_mosi_o,
   output logic [4:0]           bit_cnt_o,
   output logic [WORD_BITS-1:0] rx_word_o
);

   logic                 sck_q, sck_d;
   logic                 mosi_q, mosi_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [WORD_BITS-1:0] tx_q, tx_d;
   logic [WORD_BITS-1:0] rx_q, rx_d;

   // Next-state: a low phase is followed by a high phase that samples MISO; the edge
   // leaving the high phase advances the bit and shifts out the next MOSI bit.
   always_comb begin
      sck_d  = sck_q;
      mosi_d = mosi_q;
      cnt_d  = cnt_q;
      tx_d   = tx_q;
      rx_d   = rx_q;
      if (abort_i) begin
         sck_d  = 1'b0;
         mosi_d = 1'b0;
         cnt_d  = '0;
      end else if (start_i) begin
         sck_d  = 1'b0;
         mosi_d = frame_i[WORD_BITS-1];
         tx_d   = {frame_i[WORD_BITS-2:0], 1'b0};
         cnt_d  = '0;
      end else if (run_i && !hold_i) begin
         if (!sck_q) begin
            sck_d                      = 1'b1;
            rx_d[rx_bit_index(cnt_q)]  = spi_miso_i;
         end else begin
            sck_d  = 1'b0;
            cnt_d  = cnt_q + 5'd1;
            mosi_d = tx_q[WORD_BITS-1];
            tx_d   = {tx_q[WORD_BITS-2:0], 1'b0};
         end
      end
   end

   // Bit engine state, synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sck_q  <= 1'b0;
         mosi_q <= 1'b0;
         cnt_q  <= '0;
         tx_q   <= '0;
         rx_q   <= '0;
      end else begin
         sck_q  <= sck_d;
         mosi_q <= mosi_d;
         cnt_q  <= cnt_d;
         tx_q   <= tx_d;
         rx_q   <= rx_d;
      end
   end

   assign spi_sck_o  = sck_q;
   assign spi_mosi_o = mosi_q;
   assign bit_cnt_o  = cnt_q;
   assign rx_word_o  = rx_q;

endmodule

// File: rtl/nanov_spi_fetch.sv
// nanoV instruction fetch: continuous SPI READ stream into a one-word presented slot.
module nanov_spi_fetch
   import nanov_fetch_pkg::*;
#(
   parameter logic [ADDR_BITS-1:0] RESET_ADDR     = 24'h000000,
   parameter int unsigned          CS_HIGH_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [WORD_BITS-1:0] instr,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   output logic [ADDR_BITS-1:0] pc,
   input  logic                 jump,
   input  logic [ADDR_BITS-1:0] jump_addr,
   output logic                 spi_cs_n,
   output logic                 spi_sck,
   output logic                 spi_mosi,
   input  logic                 spi_miso
);

   localparam logic [ADDR_BITS-1:0] ResetWord = {RESET_ADDR[ADDR_BITS-1:2], 2'b00};
   localparam logic [3:0]           DeselLast = 4'(CS_HIGH_CYCLES - 1);

   fetch_state_e         state_q;
   logic [3:0]           desel_cnt_q;
   logic [ADDR_BITS-1:0] fetch_q;
   logic [ADDR_BITS-1:0] pc_q;
   logic [WORD_BITS-1:0] instr_q;
   logic                 valid_q;
   logic                 cs_n_q;

   logic                 start;
   logic                 abort;
   logic                 run;
   logic                 hold;
   logic [4:0]           bit_cnt;
   logic [WORD_BITS-1:0] rx_word;
   logic                 bit_last;

   // PHY control decoded from the current state.
   always_comb begin
      start    = !jump && (state_q == StDesel) && (desel_cnt_q == DeselLast);
      abort    = jump || ((state_q == StDesel) && !start);
      run      = (state_q != StDesel);
      hold     = (state_q == StStall);
      bit_last = spi_sck && (bit_cnt == 5'd31);
   end

   nanov_spi_phy u_phy (
      .clk_i      (clk),
      .rst_i      (rst),
      .abort_i    (abort),
      .start_i    (start),
      .frame_i    ({SPI_READ_CMD, fetch_q}),
      .run_i      (run),
      .hold_i     (hold),
      .spi_miso_i (spi_miso),
      .spi_sck_o  (spi_sck),
      .spi_mosi_o (spi_mosi),
      .bit_cnt_o  (bit_cnt),
      .rx_word_o  (rx_word)
   );

   // Fetch FSM, presented slot and jump handling; jump overrides everything but reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StDesel;
         desel_cnt_q <= '0;
         fetch_q     <= ResetWord;
         pc_q        <= ResetWord;
         instr_q     <= '0;
         valid_q     <= 1'b0;
         cs_n_q      <= 1'b1;
      end else if (jump) begin
         state_q     <= StDesel;
         desel_cnt_q <= '0;
         fetch_q     <= {jump_addr[ADDR_BITS-1:2], 2'b00};
         valid_q     <= 1'b0;
         cs_n_q      <= 1'b1;
      end else begin
         if (valid_q && instr_ready) valid_q <= 1'b0;
         unique case (state_q)
            StDesel: begin
               if (desel_cnt_q == DeselLast) begin
                  state_q <= StCmd;
                  cs_n_q  <= 1'b0;
               end else begin
                  desel_cnt_q <= desel_cnt_q + 4'd1;
               end
            end
            StCmd: begin
               if (spi_sck && (bit_cnt == 5'd7)) state_q <= StAddr;
            end
            StAddr: begin
               if (bit_last) state_q <= StData;
            end
            StData: begin
               if (bit_last) begin
                  if (!valid_q || instr_ready) begin
                     instr_q <= rx_word;
                     pc_q    <= fetch_q;
                     valid_q <= 1'b1;
                     fetch_q <= fetch_q + 24'd4;
                  end else begin
                     state_q <= StStall;
                  end
               end
            end
            StStall: begin
               // The slot is always full here, so ready means it frees this edge.
               if (instr_ready) begin
                  instr_q <= rx_word;
                  pc_q    <= fetch_q;
                  valid_q <= 1'b1;
                  fetch_q <= fetch_q + 24'd4;
                  state_q <= StData;
               end
            end
            default: state_q <= StDesel;
         endcase
      end
   end

   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign spi_cs_n    = cs_n_q;

endmodule

// File: doc/nanov_spi_fetch.md
# nanov_spi_fetch

Instruction fetch stage for the bit-serial nanoV core: streams 32-bit RISC-V instructions from an external SPI flash/RAM using a continuous READ (0x03) and presents them word-by-word to the core through a valid/ready handshake. It holds one presented word plus one word in flight. On a taken branch or jump it restarts the SPI transaction at a new word-aligned address. It sits directly upstream of the core and supplies its `instr` input.

## Interface
Parameters:
- `RESET_ADDR`, default 24'h000000: byte address of the first fetch after reset; bits [1:0] are treated as 0.
- `CS_HIGH_CYCLES`, default 2: minimum number of clk cycles `spi_cs_n` is held high between transactions; legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `instr`  out  32  presented instruction word, little-endian assembled.
- `instr_valid`  out  1  `instr` and `pc` hold a valid word.
- `instr_ready`  in  1  core accepts the word; a transfer occurs when valid && ready.
- `pc`  out  24  byte address of `instr`.
- `jump`  in  1  single-cycle request to restart fetching at `jump_addr`.
- `jump_addr`  in  24  new fetch address; bits [1:0] are ignored and forced to 0.
- `spi_cs_n`  out  1  flash chip select, active-low.
- `spi_sck`  out  1  SPI clock, mode 0, frequency clk/2.
- `spi_mosi`  out  1  command and address bits, MSB first.
- `spi_miso`  in  1  read data.

## Operation
- States: DESEL, CMD, ADDR, DATA, STALL.
  - DESEL: `spi_cs_n`=1, `spi_sck`=0.
  - CMD: 8 bits of 0x03.
  - ADDR: 24-bit fetch address, MSB first.
  - DATA: continuous read, 32 bits per word.
  - STALL: `spi_cs_n` stays 0, `spi_sck` is held 0, nothing shifts.
- Each SPI bit occupies 2 clk: a low phase, then a high phase.
  - `spi_mosi` changes only on the edge that enters the low phase.
  - `spi_miso` is sampled on the edge that drives `spi_sck` high.
- Data assembly: received bit k (0..31) of a word is written to `instr[8*(k/8) + 7 - (k%8)]`. Flash byte at address A therefore becomes `instr[7:0]`, byte A+3 becomes `instr[31:24]`.
- Each completed word moves from the shift register into the presented slot when that slot is empty or being consumed in the same cycle. That `pc` = fetch address of the word; the fetch address then advances by 4.
- If a word completes while the slot is full and not being consumed, enter STALL. Resume DATA (starting with a low phase) the cycle after the slot frees.
- Fetch address wraps modulo 2^24.
- `jump`, regardless of state:
  - On the next edge: `instr_valid`=0, the partial word is discarded, `spi_cs_n`=1, state=DESEL, fetch address=`jump_addr` & ~3.
  - The state returns to CMD after `CS_HIGH_CYCLES` cycles in DESEL.
  - If a valid && ready handshake coincides with `jump`, the handshake completes; the core owns that word.
  - `jump` while already in DESEL restarts the DESEL count with the new address.
- Reset mid-transaction aborts it unconditionally; no SPI bit completes afterwards.

## Timing
- Reset values:
  - `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0.
  - `instr`=0, `instr_valid`=0.
  - `pc`=RESET_ADDR & ~3, state=DESEL.
- After reset, DESEL lasts `CS_HIGH_CYCLES` cycles, then `spi_cs_n` falls. The same edge drives `spi_mosi`=0 (CMD bit 7).
- CMD + ADDR take 64 clk, and each data word takes 64 clk.
- First `instr_valid` rises on the 128th edge after the edge that drove `spi_cs_n` low.
- With `instr_ready` held 1, subsequent words present every 64 clk with no STALL.
- Jump-to-valid latency: 1 + `CS_HIGH_CYCLES` + 128 edges.
- `instr` and `pc` are stable while valid && !ready.
- `instr_ready` has no combinational path to any output.

## Structure
- Package `nanov_fetch_pkg`: the state enum, `SPI_READ_CMD`=8'h03, `ADDR_BITS`=24, `WORD_BITS`=32.
- One sub-module, `nanov_spi_phy`, owns:
  - sck phase generation;
  - the MOSI shift-out register;
  - MISO sampling with its bit counter;
  - a hold input that forces the STALL behaviour.
- The top level owns the state machine, fetch address, presented slot, and jump handling.

## Test plan
- Reset fetch: flash model bytes 13 05 10 00 at address 0, `instr_ready`=1.
  - MOSI carries 0x03 then 0x000000.
  - `instr_valid` rises 128 edges after `spi_cs_n` falls, with `instr`=0x00100513 and `pc`=0.
- Back-to-back: words at 0, 4, 8 with `instr_ready`=1.
  - Valid pulses exactly 64 clk apart with `pc`=0, 4, 8.
  - `spi_cs_n` never rises.
- Stall: `instr_ready`=0 for 300 cycles after the first valid.
  - The second word completes, then `spi_sck` stays 0 with `spi_cs_n`=0.
  - `instr`/`pc` stay at word 0.
  - After ready rises, word 1 (`pc`=4) presents on the next edge and clocking resumes.
- Jump mid-word: `jump`=1 with `jump_addr`=0x000123 at bit 17 of a data word.
  - Next edge: valid=0 and `spi_cs_n`=1 for 2 cycles.
  - MOSI then sends 0x03 and 0x000120; the first valid has `pc`=0x000120.
- Jump coinciding with valid && ready: the handshake is counted, and no further word from the old stream is ever presented.
- Wrap and reset mid-op:
  - A jump to 0xFFFFFC yields a next `pc` of 0x000000 within the same transaction.
  - Asserting `rst` during ADDR returns every output to its reset value on the next edge.
